i2c_init_sequencer: RTL and testbench

Table-driven controller that sequences i2c_master through a device bring-up list of register writes, read-verify checks and delays. It fetches entries from a synchronous ROM and issues single-shot transactions on the master's command interface. It retries on NACK or mismatch and reports completion or failure to the system.

---
 rtl/i2c_seq_pkg.sv | 47 ++++
 rtl/i2c_seq_timer.sv | 24 ++
 rtl/i2c_init_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C init sequencer: opcodes, error codes, FSM
// encoding and table-entry field layout helpers.
package i2c_seq_pkg;

   localparam logic [1:0] OP_END    = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_VERIFY = 2'b10;
   localparam logic [1:0] OP_DELAY  = 2'b11;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_NACK     = 2'b01;
   localparam logic [1:0] ERR_MISMATCH = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_ISSUE   = 4'd3;
   localparam logic [3:0] S_WAIT    = 4'd4;
   localparam logic [3:0] S_CHECK   = 4'd5;
   localparam logic [3:0] S_GAP     = 4'd6;
   localparam logic [3:0] S_DELAY   = 4'd7;
   localparam logic [3:0] S_ADVANCE = 4'd8;
   localparam logic [3:0] S_FINISH  = 4'd9;
   localparam logic [3:0] S_FAIL    = 4'd10;

   localparam int OP_W   = 2;
   localparam int CHIP_W = 7;

   // Entry layout, MSB first: {op, chip, reg, data}
   function automatic int reg_lsb(input int data_bytes);
      return 8 * data_bytes;
   endfunction

   function automatic int chip_lsb(input int addr_bytes, input int data_bytes);
      return 8 * (addr_bytes + data_bytes);
   endfunction

   function automatic int op_lsb(input int addr_bytes, input int data_bytes);
      return 8 * (addr_bytes + data_bytes) + CHIP_W;
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter shared by the delay, retry-gap and timeout phases.
module i2c_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (!reset)
         value <= '0;
      else if (load)
         value <= load_value;
      else if (value != '0)
         value <= value - W'(1);
   end

   assign zero = (value == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Table-driven bring-up controller: walks a ROM of write / verify / delay
// entries and drives single-shot transactions on an i2c_master.
module i2c_init_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int ADDR_BYTES = 1,
   parameter int DATA_BYTES = 2,
   parameter int ST_WIDTH   = 1 + ADDR_BYTES + DATA_BYTES,
   parameter int ENTRY_W    = 9 + 8 * (ADDR_BYTES + DATA_BYTES),
   parameter int TABLE_AW   = 6,
   parameter int MAX_RETRY  = 3,
   parameter int RETRY_GAP  = 256,
   parameter int DELAY_UNIT = 1000,
   parameter int TIMEOUT    = 2**20 - 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic [TABLE_AW-1:0]     tbl_addr,
   input  logic [ENTRY_W-1:0]      tbl_data,
   output logic [6:0]              m_chip_addr,
   output logic [8*ADDR_BYTES-1:0] m_reg_addr,
   output logic [8*DATA_BYTES-1:0] m_wdata,
   output logic                    m_write_en,
   output logic                    m_read_en,
   output logic                    m_write_mode,
   input  logic [8*DATA_BYTES-1:0] m_rdata,
   input  logic [ST_WIDTH-1:0]     m_status,
   input  logic                    m_done,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [1:0]              err_code,
   output logic [TABLE_AW-1:0]     err_index,
   output logic [3:0]              state
);

   localparam int RA_W     = 8 * ADDR_BYTES;
   localparam int D_W      = 8 * DATA_BYTES;
   localparam int REG_LSB  = reg_lsb(DATA_BYTES);
   localparam int CHIP_LSB = chip_lsb(ADDR_BYTES, DATA_BYTES);
   localparam int OP_LSB   = op_lsb(ADDR_BYTES, DATA_BYTES);
   localparam int PROD_W   = D_W + $clog2(DELAY_UNIT);
   localparam int CNT_W    = max_of(PROD_W, max_of($clog2(TIMEOUT + 1), $clog2(RETRY_GAP + 1)));
   localparam int RC_W     = max_of(1, $clog2(MAX_RETRY + 1));

   logic [OP_W-1:0]   tbl_op;
   logic [CHIP_W-1:0] tbl_chip;
   logic [RA_W-1:0]   tbl_reg;
   logic [D_W-1:0]    tbl_dat;
   logic [PROD_W-1:0] delay_prod;

   logic [OP_W-1:0]     op_q;
   logic [D_W-1:0]      data_q;
   logic [D_W-1:0]      rdata_q;
   logic [ST_WIDTH-1:0] st_q;
   logic [RC_W-1:0]     retry_cnt;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic [CNT_W-1:0] tmr_count;
   logic             tmr_zero;
   logic             nack;
   logic             mismatch;
   logic             retry_ok;

   assign tbl_op     = tbl_data[OP_LSB +: OP_W];
   assign tbl_chip   = tbl_data[CHIP_LSB +: CHIP_W];
   assign tbl_reg    = tbl_data[REG_LSB +: RA_W];
   assign tbl_dat    = tbl_data[0 +: D_W];
   assign delay_prod = PROD_W'(tbl_dat) * PROD_W'(DELAY_UNIT);

   assign nack     = |st_q;
   assign mismatch = (op_q == OP_VERIFY) && (rdata_q != data_q);
   assign retry_ok = (retry_cnt < RC_W'(MAX_RETRY));

   assign m_write_en   = (state == S_ISSUE) && (op_q == OP_WRITE);
   assign m_read_en    = (state == S_ISSUE) && (op_q == OP_VERIFY);
   assign m_write_mode = 1'b0;
   assign done         = (state == S_FINISH);

   // Delay and gap phases last exactly their load value in cycles (exit at 1);
   // the timeout phase exits when the counter has run down to zero.
   always_comb begin
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state)
         S_DECODE: if (tbl_op == OP_DELAY && tbl_dat != '0) begin
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(delay_prod);
         end
         S_ISSUE: begin
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(TIMEOUT - 1);
         end
         S_CHECK: if ((nack || mismatch) && retry_ok) begin
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(RETRY_GAP);
         end
         default: ;
      endcase
   end

   i2c_seq_timer #(.W(CNT_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (tmr_load),
      .load_value (tmr_value),
      .value      (tmr_count),
      .zero       (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         tbl_addr    <= '0;
         m_chip_addr <= '0;
         m_reg_addr  <= '0;
         m_wdata     <= '0;
         busy        <= 1'b0;
         error       <= 1'b0;
         err_code    <= ERR_NONE;
         err_index   <= '0;
         op_q        <= OP_END;
         data_q      <= '0;
         rdata_q     <= '0;
         st_q        <= '0;
         retry_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               error     <= 1'b0;
               err_code  <= ERR_NONE;
               err_index <= '0;
               busy      <= 1'b1;
               tbl_addr  <= '0;
               retry_cnt <= '0;
               state     <= S_FETCH;
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               op_q   <= tbl_op;
               data_q <= tbl_dat;
               case (tbl_op)
                  OP_END:   state <= S_FINISH;
                  OP_DELAY: state <= (tbl_dat == '0) ? S_ADVANCE : S_DELAY;
                  default: begin
                     m_chip_addr <= tbl_chip;
                     m_reg_addr  <= tbl_reg;
                     m_wdata     <= tbl_dat;
                     state       <= S_ISSUE;
                  end
               endcase
            end
            S_ISSUE: state <= S_WAIT;
            // Capture the result on m_done so CHECK does not depend on the master holding it.
            S_WAIT: if (m_done) begin
               st_q    <= m_status;
               rdata_q <= m_rdata;
               state   <= S_CHECK;
            end else if (tmr_zero) begin
               err_code <= ERR_TIMEOUT;
               state    <= S_FAIL;
            end
            S_CHECK: if (nack || mismatch) begin
               if (retry_ok) begin
                  retry_cnt <= retry_cnt + RC_W'(1);
                  state     <= S_GAP;
               end else begin
                  err_code <= nack ? ERR_NACK : ERR_MISMATCH;
                  state    <= S_FAIL;
               end
            end else begin
               retry_cnt <= '0;
               state     <= S_ADVANCE;
            end
            S_GAP:   if (tmr_count == CNT_W'(1)) state <= S_ISSUE;
            S_DELAY: if (tmr_count == CNT_W'(1)) state <= S_ADVANCE;
            S_ADVANCE: if (&tbl_addr) begin
               state <= S_FINISH;
            end else begin
               tbl_addr <= tbl_addr + TABLE_AW'(1);
               state    <= S_FETCH;
            end
            S_FINISH: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_FAIL: begin
               error     <= 1'b1;
               err_index <= tbl_addr;
               busy      <= 1'b0;
               retry_cnt <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a ROM model and a simple
// i2c_master response model driven on the falling edge.
module tb_i2c_init_sequencer;
   import i2c_seq_pkg::*;

   localparam int AW   = 6;
   localparam int EW   = 33;
   localparam int ST_W = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] tbl_addr;
   logic [EW-1:0] tbl_data = '0;
   logic [6:0]    m_chip_addr;
   logic [7:0]    m_reg_addr;
   logic [15:0]   m_wdata;
   logic          m_write_en, m_read_en, m_write_mode;
   logic [15:0]   m_rdata = '0;
   logic [ST_W-1:0] m_status = '0;
   logic          m_done = 1'b0;
   logic          busy, done, error;
   logic [1:0]    err_code;
   logic [AW-1:0] err_index;
   logic [3:0]    state;

   i2c_init_sequencer #(
      .RETRY_GAP  (256),
      .DELAY_UNIT (4),
      .TIMEOUT    (50)
   ) dut (
      .clk (clk), .reset (reset), .start (start),
      .tbl_addr (tbl_addr), .tbl_data (tbl_data),
      .m_chip_addr (m_chip_addr), .m_reg_addr (m_reg_addr), .m_wdata (m_wdata),
      .m_write_en (m_write_en), .m_read_en (m_read_en), .m_write_mode (m_write_mode),
      .m_rdata (m_rdata), .m_status (m_status), .m_done (m_done),
      .busy (busy), .done (done), .error (error),
      .err_code (err_code), .err_index (err_index), .state (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [EW-1:0] rom [64];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   // master model controls
   int          nack_left = 0;
   bit          nack_chip_en = 0;
   logic [6:0]  nack_chip = '0;
   bit          hang = 0;
   logic [15:0] model_rdata = '0;
   int          lat = 0;

   // observation logs
   logic [30:0] exp_q[$];
   logic [30:0] tx_q[$];
   bit          tx_w[$];
   int          tx_cyc[$];
   int          chk_cyc[$];
   int          dec_cyc[$];
   int          fetch_cyc[$];
   int          done_cnt, delay_cyc, wait_cyc;

   int tests = 0;
   int failed = 0;

   always @(negedge clk) begin
      m_done = 1'b0;
      if (lat > 0) begin
         lat--;
         if (lat == 0) begin
            m_done = 1'b1;
            if ((nack_chip_en && m_chip_addr == nack_chip) || nack_left > 0) begin
               m_status = 4'b0001;
               if (nack_left > 0) nack_left--;
            end else begin
               m_status = '0;
            end
            m_rdata = model_rdata;
         end
      end
      if (m_write_en || m_read_en) begin
         tx_q.push_back({m_chip_addr, m_reg_addr, m_wdata});
         tx_w.push_back(m_write_en);
         tx_cyc.push_back(cyc);
         if (!hang) lat = 3;
      end
      if (done) done_cnt++;
      if (state == S_DELAY) delay_cyc++;
      if (state == S_WAIT) wait_cyc++;
      if (state == S_CHECK) chk_cyc.push_back(cyc);
      if (state == S_DECODE) dec_cyc.push_back(cyc);
      if (state == S_FETCH) fetch_cyc.push_back(cyc);
   end

   function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [6:0] ch,
                                         input logic [7:0] r, input logic [15:0] d);
      return {op, ch, r, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = '0;
   endtask

   task automatic clear_logs();
      exp_q.delete(); tx_q.delete(); tx_w.delete(); tx_cyc.delete();
      chk_cyc.delete(); dec_cyc.delete(); fetch_cyc.delete();
      done_cnt = 0; delay_cyc = 0; wait_cyc = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input string tag, input int budget);
      clear_logs();
      pulse_start();
      wait_idle(tag, budget);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_rom();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", {28'd0, state}, {28'd0, S_IDLE});
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_err_index", {26'd0, err_index}, 32'd0);
      chk("rst_tbl_addr", {26'd0, tbl_addr}, 32'd0);
      chk("rst_en", {30'd0, m_write_en, m_read_en}, 32'd0);
      chk("rst_master_bus", {m_chip_addr, m_reg_addr, m_wdata}, 32'd0);
      chk("rst_write_mode", {31'd0, m_write_mode}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // two writes then END, always ACK
      clear_rom();
      rom[0] = ent(OP_WRITE, 7'h3C, 8'h10, 16'hABCD);
      rom[1] = ent(OP_WRITE, 7'h3C, 8'h11, 16'h0001);
      run("t1", 500);
      exp_q.push_back({7'h3C, 8'h10, 16'hABCD});
      exp_q.push_back({7'h3C, 8'h11, 16'h0001});
      chk("t1_tx_count", tx_q.size(), 32'd2);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("t1_tx%0d", i), {1'b0, tx_q[i]}, {1'b0, exp_q[i]});
         chk($sformatf("t1_is_write%0d", i), {31'd0, tx_w[i]}, 32'd1);
      end
      chk("t1_done_cnt", done_cnt, 32'd1);
      chk("t1_error", {31'd0, error}, 32'd0);

      // NACK twice then ACK
      clear_rom();
      rom[0] = ent(OP_WRITE, 7'h3C, 8'h20, 16'h5555);
      nack_left = 2;
      run("t2", 2000);
      chk("t2_tx_count", tx_q.size(), 32'd3);
      chk("t2_check_count", chk_cyc.size(), 32'd3);
      for (int i = 1; i < 3; i++)
         chk($sformatf("t2_gap%0d", i), {31'd0, (tx_cyc[i] - chk_cyc[i-1]) >= 256}, 32'd1);
      chk("t2_done_cnt", done_cnt, 32'd1);
      chk("t2_error", {31'd0, error}, 32'd0);

      // persistent NACK at entry 2
      clear_rom();
      rom[0] = ent(OP_WRITE, 7'h3C, 8'h01, 16'h0011);
      rom[1] = ent(OP_WRITE, 7'h3C, 8'h02, 16'h0022);
      rom[2] = ent(OP_WRITE, 7'h50, 8'h03, 16'h0033);
      nack_chip_en = 1; nack_chip = 7'h50;
      run("t3", 3000);
      nack_chip_en = 0;
      chk("t3_tx_count", tx_q.size(), 32'd6);
      chk("t3_error", {31'd0, error}, 32'd1);
      chk("t3_err_code", {30'd0, err_code}, {30'd0, ERR_NACK});
      chk("t3_err_index", {26'd0, err_index}, 32'd2);
      chk("t3_done_cnt", done_cnt, 32'd0);

      // VERIFY mismatch, then match
      clear_rom();
      rom[0] = ent(OP_VERIFY, 7'h3C, 8'h05, 16'h1234);
      model_rdata = 16'h1235;
      run("t4a", 3000);
      chk("t4a_tx_count", tx_q.size(), 32'd4);
      chk("t4a_is_read", {31'd0, tx_w[0]}, 32'd0);
      chk("t4a_err_code", {30'd0, err_code}, {30'd0, ERR_MISMATCH});
      chk("t4a_error", {31'd0, error}, 32'd1);
      chk("t4a_done_cnt", done_cnt, 32'd0);
      model_rdata = 16'h1234;
      run("t4b", 500);
      chk("t4b_tx_count", tx_q.size(), 32'd1);
      chk("t4b_done_cnt", done_cnt, 32'd1);
      chk("t4b_error", {31'd0, error}, 32'd0);
      chk("t4b_err_code", {30'd0, err_code}, 32'd0);

      // DELAY holds for N*DELAY_UNIT cycles on top of DECODE->ADVANCE->FETCH
      clear_rom();
      rom[0] = ent(OP_DELAY, 7'h00, 8'h00, 16'd3);
      run("t5a", 500);
      chk("t5a_delay_cycles", delay_cyc, 32'd12);
      chk("t5a_decode_to_fetch", fetch_cyc[1] - dec_cyc[0], 32'd14);
      chk("t5a_done_cnt", done_cnt, 32'd1);
      rom[0] = ent(OP_DELAY, 7'h00, 8'h00, 16'd0);
      run("t5b", 500);
      chk("t5b_delay_cycles", delay_cyc, 32'd0);
      chk("t5b_decode_to_fetch", fetch_cyc[1] - dec_cyc[0], 32'd2);

      // master never answers; a second start while busy is ignored
      clear_rom();
      rom[0] = ent(OP_WRITE, 7'h3C, 8'h30, 16'hBEEF);
      hang = 1;
      clear_logs();
      pulse_start();
      repeat (10) @(negedge clk);
      pulse_start();
      wait_idle("t6", 500);
      hang = 0;
      chk("t6_tx_count", tx_q.size(), 32'd1);
      chk("t6_wait_cycles", wait_cyc, 32'd50);
      chk("t6_err_code", {30'd0, err_code}, {30'd0, ERR_TIMEOUT});
      chk("t6_error", {31'd0, error}, 32'd1);
      chk("t6_err_index", {26'd0, err_index}, 32'd0);
      chk("t6_done_cnt", done_cnt, 32'd0);

      // full 64-entry table without END
      for (int i = 0; i < 64; i++) rom[i] = ent(OP_DELAY, 7'h00, 8'h00, 16'd0);
      rom[63] = ent(OP_WRITE, 7'h3C, 8'h3F, 16'h0063);
      run("t7", 2000);
      chk("t7_fetch_count", fetch_cyc.size(), 32'd64);
      chk("t7_tx_count", tx_q.size(), 32'd1);
      chk("t7_last_tx", {1'b0, tx_q[0]}, {1'b0, 7'h3C, 8'h3F, 16'h0063});
      chk("t7_tbl_addr", {26'd0, tbl_addr}, 32'd63);
      chk("t7_done_cnt", done_cnt, 32'd1);
      chk("t7_error", {31'd0, error}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
